// File: rtl/key_seq_detect_multi_pkg.sv
// Shared constants and elaboration helpers for the key sequence detector.
// Widths derive from parameters so the same code serves any PAT_LEN.
package key_seq_detect_multi_pkg;

    localparam int MAX_PAT_LEN = 16;

    function automatic bit pat_len_ok(input int n);
        return (n >= 1) && (n <= MAX_PAT_LEN);
    endfunction

    function automatic bit pattern_fits(input int n, input longint unsigned p);
        return (n >= 64) || ((p >> n) == 0);
    endfunction

    function automatic int state_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a counter that must hold 0..max_val, never zero bits.
    function automatic int ctr_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_seq_detect_multi_if.sv
// Board-side bundle: raw key/switch/mode/clear in, pulses and status out.
// The detector uses the slave view; the driving logic uses master.
interface key_seq_detect_multi_if #(
    parameter int SC_W  = 3,
    parameter int CNT_W = 8
);
    logic             key;
    logic             sw;
    logic             overlap;
    logic             clr;
    logic             press;
    logic             match;
    logic             led;
    logic [SC_W-1:0]  state_count;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output key, sw, overlap, clr,
        input  press, match, led, state_count, match_cnt
    );

    modport slave (
        input  key, sw, overlap, clr,
        output press, match, led, state_count, match_cnt
    );
endinterface

// File: rtl/key_seq_detect_multi_key_debounce_tick.sv
// Key debouncer: sample tick, consecutive-tick level filter, press edge.
// Presses are armed only after the key has been seen released.
module key_debounce_tick
    import key_seq_detect_multi_pkg::*;
#(
    parameter int DIV_CYC   = 50000,
    parameter int DEB_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_sync,
    output logic press,
    output logic key_stable
);
    localparam int TICK_W = ctr_w(DIV_CYC - 1);
    localparam int DEB_W  = ctr_w(DEB_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              stable_q, stable_d;
    logic              armed_q, armed_d;
    logic              press_q, press_d;
    logic              tick;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        deb_cnt_d  = deb_cnt_q;
        stable_d   = stable_q;
        armed_d    = armed_q | key_sync;
        if (tick) begin
            if (key_sync != stable_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    stable_d  = ~stable_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end else begin
                deb_cnt_d = '0;
            end
        end
        // A key held through reset settles low silently.
        press_d = armed_q & stable_q & ~stable_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            deb_cnt_q  <= '0;
            stable_q   <= 1'b1;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            stable_q   <= stable_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
        end
    end

    assign press      = press_q;
    assign key_stable = stable_q;

endmodule

// File: rtl/key_seq_detect_multi.sv
// Key/switch sequence detector: synchronisers, debounced press, pattern
// matcher with overlap mode, LED hold timer and saturating match counter.
module key_seq_detect_multi
    import key_seq_detect_multi_pkg::*;
#(
    parameter int               DIV_CYC   = 50000,
    parameter int               DEB_TICKS = 20,
    parameter int               PAT_LEN   = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter int               LED_HOLD  = 25000000,
    parameter int               CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    key_seq_detect_multi_if.slave io
);
    localparam int SC_W  = state_w(PAT_LEN);
    localparam int TMR_W = ctr_w(LED_HOLD);
    localparam logic [SC_W-1:0]  FULL   = SC_W'(PAT_LEN);
    localparam logic [SC_W-1:0]  PROPER = SC_W'(PAT_LEN - 1);
    localparam logic [TMR_W-1:0] HOLD   = TMR_W'(LED_HOLD);

    if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
        $error("PAT_LEN must be within 1..16");
    end
    if (!pattern_fits(PAT_LEN, 64'(PATTERN))) begin : g_bad_pattern
        $error("PATTERN wider than PAT_LEN");
    end

    logic [1:0]         key_sync_q, key_sync_d;
    logic [1:0]         sw_sync_q, sw_sync_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [SC_W-1:0]    vlen_q, vlen_d;
    logic [SC_W-1:0]    state_q, state_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               press;
    logic               key_stable;
    logic [PAT_LEN:0]   shifted;
    logic [SC_W-1:0]    full_k;

    // Longest k <= lim whose newest k history bits equal the pattern head.
    function automatic logic [SC_W-1:0] best_k(
        input logic [PAT_LEN-1:0] h,
        input logic [SC_W-1:0]    lim
    );
        logic [SC_W-1:0]    best;
        logic [PAT_LEN-1:0] head;
        logic [PAT_LEN-1:0] mask;
        best = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            head = PATTERN >> (PAT_LEN - k);
            mask = PAT_LEN'((64'd1 << k) - 64'd1);
            if ((k <= int'(lim)) && (((h ^ head) & mask) == '0)) begin
                best = SC_W'(k);
            end
        end
        return best;
    endfunction

    always_comb begin
        key_sync_d = {key_sync_q[0], io.key};
        sw_sync_d  = {sw_sync_q[0], io.sw};
    end

    key_debounce_tick #(
        .DIV_CYC   (DIV_CYC),
        .DEB_TICKS (DEB_TICKS)
    ) u_deb (
        .clk        (clk),
        .rst        (rst),
        .key_sync   (key_sync_q[1]),
        .press      (press),
        .key_stable (key_stable)
    );

    always_comb begin
        hist_d  = hist_q;
        vlen_d  = vlen_q;
        state_d = state_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
        shifted = {hist_q, sw_sync_q[1]};
        full_k  = '0;
        // Clear wins over a press in the same cycle.
        if (io.clr) begin
            hist_d  = '0;
            vlen_d  = '0;
            state_d = '0;
            cnt_d   = '0;
            timer_d = '0;
        end else if (press) begin
            hist_d = shifted[PAT_LEN-1:0];
            vlen_d = (vlen_q == FULL) ? FULL : vlen_q + 1'b1;
            full_k = best_k(hist_d, vlen_d);
            if (full_k == FULL) begin
                match_d = 1'b1;
                timer_d = HOLD;
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (io.overlap) begin
                    state_d = best_k(hist_d, PROPER);
                end else begin
                    state_d = '0;
                    vlen_d  = '0;
                end
            end else begin
                state_d = full_k;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sync_q <= '0;
            sw_sync_q  <= '0;
            hist_q     <= '0;
            vlen_q     <= '0;
            state_q    <= '0;
            match_q    <= 1'b0;
            cnt_q      <= '0;
            timer_q    <= '0;
        end else begin
            key_sync_q <= key_sync_d;
            sw_sync_q  <= sw_sync_d;
            hist_q     <= hist_d;
            vlen_q     <= vlen_d;
            state_q    <= state_d;
            match_q    <= match_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign io.press       = press;
    assign io.match       = match_q;
    assign io.led         = (timer_q != '0);
    assign io.state_count = state_q;
    assign io.match_cnt   = cnt_q;

    logic unused_stable;
    assign unused_stable = key_stable;

endmodule

// File: tb/tb_key_seq_detect_multi.sv
// Bench for key_seq_detect_multi: scenario tasks plus randomized presses
// checked against a queue-based sequence model.
module tb_key_seq_detect_multi;
    import key_seq_detect_multi_pkg::*;

    localparam int PL = 5;
    localparam logic [PL-1:0] PAT = 5'b10110;
    localparam int HOLD1 = 10;
    localparam int HOLD2 = 200;
    localparam int SCW = state_w(PL);

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   mq[$];
    int   exp_cnt;
    int   exp_state;

    key_seq_detect_multi_if #(.SC_W(SCW), .CNT_W(2)) io ();
    key_seq_detect_multi_if #(.SC_W(SCW), .CNT_W(2)) io2 ();

    assign io2.key     = io.key;
    assign io2.sw      = io.sw;
    assign io2.overlap = io.overlap;
    assign io2.clr     = io.clr;

    key_seq_detect_multi #(
        .DIV_CYC(4), .DEB_TICKS(3), .PAT_LEN(PL),
        .PATTERN(PAT), .LED_HOLD(HOLD1), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    key_seq_detect_multi #(
        .DIV_CYC(4), .DEB_TICKS(3), .PAT_LEN(PL),
        .PATTERN(PAT), .LED_HOLD(HOLD2), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst(rst), .io(io2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest tail of the entered bits that equals the pattern's head.
    function automatic int longest(input int lim);
        int best;
        int n;
        bit ok;
        best = 0;
        n = mq.size();
        for (int k = 1; k <= lim && k <= n; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (mq[n - k + i] != PAT[PL - 1 - i]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    task automatic model_press(input bit b, input bit ov, output bit em);
        int k;
        mq.push_back(b);
        if (mq.size() > PL) void'(mq.pop_front());
        k = longest(PL);
        em = (k == PL);
        if (em) begin
            if (exp_cnt < 3) exp_cnt++;
            if (ov) begin
                exp_state = longest(PL - 1);
            end else begin
                mq.delete();
                exp_state = 0;
            end
        end else begin
            exp_state = k;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_cnt = 0;
        exp_state = 0;
    endtask

    // Leaves the key held low; returns in the cycle after the press pulse.
    task automatic do_press(input bit b, input bit ov);
        int waited;
        bit em;
        io.sw = b;
        io.overlap = ov;
        repeat (3) @(negedge clk);
        io.key = 1'b0;
        waited = 0;
        while (io.press !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (io.press !== 1'b1) begin
            failures++;
            $display("FAIL press_seen: press=%b want 1", io.press);
            return;
        end
        model_press(b, ov, em);
        @(negedge clk);
        checks++;
        if (io.press !== 1'b0) begin
            failures++;
            $display("FAIL press_width: press=%b want 0", io.press);
        end
        checks++;
        if (io.match !== em) begin
            failures++;
            $display("FAIL match: got %b want %b", io.match, em);
        end
        checks++;
        if (io.state_count !== SCW'(exp_state)) begin
            failures++;
            $display("FAIL state_count: got %0d want %0d", io.state_count, exp_state);
        end
        checks++;
        if (io.match_cnt !== 2'(exp_cnt)) begin
            failures++;
            $display("FAIL match_cnt: got %0d want %0d", io.match_cnt, exp_cnt);
        end
    endtask

    task automatic release_key();
        int pulses;
        io.key = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (io.press === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL release_press: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic press_rel(input bit b, input bit ov);
        do_press(b, ov);
        release_key();
    endtask

    task automatic clear_all();
        io.clr = 1'b1;
        @(negedge clk);
        io.clr = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (io.state_count !== '0 || io.match_cnt !== '0 || io.led !== 1'b0) begin
            failures++;
            $display("FAIL clear: sc=%0d cnt=%0d led=%b want 0 0 0",
                     io.state_count, io.match_cnt, io.led);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.key = 1'b1;
        io.sw = 1'b0;
        io.overlap = 1'b0;
        io.clr = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({io.press, io.match, io.led, io.state_count, io.match_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_hold: outs=%b want 0",
                     {io.press, io.match, io.led, io.state_count, io.match_cnt});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({io.press, io.match, io.led, io.state_count, io.match_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_release: outs=%b want 0",
                     {io.press, io.match, io.led, io.state_count, io.match_cnt});
        end
    endtask

    task automatic test_debounce();
        int pulses;
        io.key = 1'b0;
        repeat (8) @(negedge clk);
        io.key = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.press === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch: got %0d pulses want 0", pulses);
        end
        do_press(1'b1, 1'b0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (io.press === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL hold_extra: got %0d pulses want 0", pulses);
        end
        release_key();
        clear_all();
    endtask

    task automatic test_fallback();
        clear_all();
        press_rel(1'b1, 1'b0);
        press_rel(1'b0, 1'b0);
        press_rel(1'b1, 1'b0);
        press_rel(1'b0, 1'b0);
        checks++;
        if (io.state_count !== SCW'(2)) begin
            failures++;
            $display("FAIL fallback_end: got %0d want 2", io.state_count);
        end
    endtask

    task automatic run_seq(input bit ov);
        bit [7:0] seq;
        seq = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) press_rel(seq[i], ov);
    endtask

    task automatic test_overlap();
        clear_all();
        run_seq(1'b1);
        checks++;
        if (io.match_cnt !== 2'd2) begin
            failures++;
            $display("FAIL overlap_cnt: got %0d want 2", io.match_cnt);
        end
        clear_all();
        run_seq(1'b0);
        checks++;
        if (io.match_cnt !== 2'd1 || io.state_count !== SCW'(2)) begin
            failures++;
            $display("FAIL nonoverlap_end: cnt=%0d sc=%0d want 1 2",
                     io.match_cnt, io.state_count);
        end
    endtask

    task automatic test_led();
        int lit;
        clear_all();
        checks++;
        if (io.led !== 1'b0) begin
            failures++;
            $display("FAIL led_idle: got %b want 0", io.led);
        end
        press_rel(1'b1, 1'b1);
        press_rel(1'b0, 1'b1);
        press_rel(1'b1, 1'b1);
        press_rel(1'b1, 1'b1);
        do_press(1'b0, 1'b1);
        lit = 0;
        while (io.led === 1'b1 && lit < 50) begin
            lit++;
            @(negedge clk);
        end
        checks++;
        if (lit != HOLD1) begin
            failures++;
            $display("FAIL led_hold: got %0d cycles want %0d", lit, HOLD1);
        end
        release_key();
        press_rel(1'b1, 1'b1);
        press_rel(1'b1, 1'b1);
        do_press(1'b0, 1'b1);
        lit = 0;
        while (io2.led === 1'b1 && lit < HOLD2 + 50) begin
            lit++;
            @(negedge clk);
        end
        checks++;
        if (lit != HOLD2) begin
            failures++;
            $display("FAIL led_retrigger: got %0d cycles want %0d", lit, HOLD2);
        end
        release_key();
        for (int r = 0; r < 2; r++) begin
            press_rel(1'b1, 1'b1);
            press_rel(1'b1, 1'b1);
            press_rel(1'b0, 1'b1);
        end
        checks++;
        if (io.match_cnt !== 2'd3) begin
            failures++;
            $display("FAIL saturate: got %0d want 3", io.match_cnt);
        end
    endtask

    task automatic test_clr_press();
        int waited;
        clear_all();
        run_seq(1'b1);
        io.sw = 1'b1;
        repeat (3) @(negedge clk);
        io.key = 1'b0;
        waited = 0;
        while (io.press !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        io.clr = 1'b1;
        @(negedge clk);
        io.clr = 1'b0;
        model_clear();
        checks++;
        if (io.state_count !== '0 || io.match_cnt !== '0 || io.match !== 1'b0) begin
            failures++;
            $display("FAIL clr_press: sc=%0d cnt=%0d match=%b want 0 0 0",
                     io.state_count, io.match_cnt, io.match);
        end
        release_key();
        press_rel(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int pulses;
        clear_all();
        press_rel(1'b1, 1'b0);
        press_rel(1'b0, 1'b0);
        press_rel(1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({io.press, io.match, io.led, io.state_count, io.match_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset: outs=%b want 0",
                     {io.press, io.match, io.led, io.state_count, io.match_cnt});
        end
        io.key = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (io.press === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL held_through_reset: got %0d pulses want 0", pulses);
        end
        release_key();
        press_rel(1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit b;
        bit ov;
        clear_all();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 11) == 0) clear_all();
            ov = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) b = PAT[PL - 1 - exp_state];
            else b = 1'($urandom_range(0, 1));
            press_rel(b, ov);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_debounce();
        test_fallback();
        test_overlap();
        test_led();
        test_clr_press();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
